// File: rtl/ppa_chunk_seq.sv
// Chunked wide adder sequencer: feeds one DATA_WIDTH-bit slice per cycle to a shared
// prefix adder, LS chunk first, rippling the chunk carry through a carry register.
module ppa_chunk_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CHUNKS = 4,
    parameter int TOTAL_WIDTH = DATA_WIDTH * NUM_CHUNKS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOTAL_WIDTH-1:0] in_a,
    input  logic [TOTAL_WIDTH-1:0] in_b,
    input  logic                   in_cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] out_sum,
    output logic                   out_cout,
    output logic                   busy,
    output logic [DATA_WIDTH-1:0]  adder_a,
    output logic [DATA_WIDTH-1:0]  adder_b,
    output logic                   adder_cin,
    input  logic [DATA_WIDTH-1:0]  adder_sum,
    input  logic                   adder_cout
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // RUN   | one chunk per cycle through the shared adder
    // DONE  | result presented until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int KW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_CHUNKS - 1);

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [TOTAL_WIDTH-1:0] a_q, a_d;
    logic [TOTAL_WIDTH-1:0] b_q, b_d;
    logic [TOTAL_WIDTH-1:0] sum_q, sum_d;
    logic                   carry_q, carry_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        busy      = 1'b0;
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                adder_cin = carry_q;
                // constant-index slice mux keeps the chunk select free of variable part-selects
                for (int i = 0; i < NUM_CHUNKS; i++) begin
                    if (k_q == KW'(i)) begin
                        adder_a = a_q[i*DATA_WIDTH +: DATA_WIDTH];
                        adder_b = b_q[i*DATA_WIDTH +: DATA_WIDTH];
                        sum_d[i*DATA_WIDTH +: DATA_WIDTH] = adder_sum;
                    end
                end
                carry_d = adder_cout;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_sum   = sum_q;
                out_cout  = carry_q;
                if (out_ready) begin
                    k_d     = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ppa_chunk_seq.sv
// Self-checking bench for ppa_chunk_seq: a 4-chunk and a 1-chunk instance, each with
// a behavioural adder, checked against plain wide-arithmetic expectations.
module tb_ppa_chunk_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 4-chunk instance
    logic        in_valid = 0, in_cin = 0, out_ready = 0;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_ready, out_valid, out_cout, busy, adder_cin, adder_cout;
    logic [31:0] out_sum;
    logic [7:0]  adder_a, adder_b, adder_sum;

    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {8'd0, adder_cin};

    ppa_chunk_seq #(.DATA_WIDTH(8), .NUM_CHUNKS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .busy(busy), .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout)
    );

    // 1-chunk instance
    logic       in_valid1 = 0, in_cin1 = 0, out_ready1 = 0;
    logic [7:0] in_a1 = '0, in_b1 = '0;
    logic       in_ready1, out_valid1, out_cout1, busy1, adder_cin1, adder_cout1;
    logic [7:0] out_sum1, adder_a1, adder_b1, adder_sum1;

    assign {adder_cout1, adder_sum1} = {1'b0, adder_a1} + {1'b0, adder_b1} + {8'd0, adder_cin1};

    ppa_chunk_seq #(.DATA_WIDTH(8), .NUM_CHUNKS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1), .out_cout(out_cout1),
        .busy(busy1), .adder_a(adder_a1), .adder_b(adder_b1), .adder_cin(adder_cin1),
        .adder_sum(adder_sum1), .adder_cout(adder_cout1)
    );

    // carry into chunk k: carry out of the low 8k bits of a+b+cin
    function automatic logic carry_into(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input int k);
        longint unsigned m;
        longint unsigned s;
        if (k == 0) return cin;
        m = (64'd1 << (8 * k)) - 64'd1;
        s = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, cin};
        return s[8*k];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if ({in_ready, out_valid, busy} !== 3'b100) begin fails++;
            $display("FAIL reset_flags got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy}); end
        tests++; if ({out_sum, out_cout} !== 33'd0) begin fails++;
            $display("FAIL reset_result got %h/%b want 0/0", out_sum, out_cout); end
        tests++; if ({adder_a, adder_b, adder_cin} !== 17'd0) begin fails++;
            $display("FAIL reset_adder got %h %h %b want 0", adder_a, adder_b, adder_cin); end
        tests++; if ({in_ready1, out_valid1, busy1, out_sum1} !== {3'b100, 8'd0}) begin fails++;
            $display("FAIL reset_n1 got %b %b %b %h", in_ready1, out_valid1, busy1, out_sum1); end
        rst = 1'b0;
    endtask

    // one operation on the 4-chunk instance, with an optional out_ready stall in DONE
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input int stall, input string name);
        logic [32:0] expv;
        int cyc;
        expv = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++;
            $display("FAIL %s_ready got %b want 1", name, in_ready); end
        in_valid = 1; in_a = a; in_b = b; in_cin = cin;
        @(negedge clk);
        in_valid = 0; in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc <= 20) begin
            out_ready = 1'($urandom);
            if (cyc <= 4) begin
                tests++;
                if (adder_a !== a[(cyc-1)*8 +: 8] || adder_b !== b[(cyc-1)*8 +: 8] ||
                    adder_cin !== carry_into(a, b, cin, cyc-1)) begin fails++;
                    $display("FAIL %s_chunk%0d got %h %h %b want %h %h %b", name, cyc-1,
                             adder_a, adder_b, adder_cin, a[(cyc-1)*8 +: 8], b[(cyc-1)*8 +: 8],
                             carry_into(a, b, cin, cyc-1)); end
            end
            @(negedge clk);
            cyc++;
        end
        tests++; if (cyc !== 5) begin fails++;
            $display("FAIL %s_latency got %0d want 5", name, cyc); end
        tests++; if ({out_cout, out_sum} !== expv || busy !== 1'b1 || adder_a !== 8'd0) begin fails++;
            $display("FAIL %s_result got %b/%h busy=%b want %b/%h busy=1", name, out_cout, out_sum,
                     busy, expv[32], expv[31:0]); end
        for (int i = 0; i < stall; i++) begin
            out_ready = 0; in_valid = 1'($urandom); in_a = $urandom;
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_cout, out_sum} !== expv) begin fails++;
                $display("FAIL %s_stall%0d got vld=%b rdy=%b %b/%h want 1 0 %b/%h", name, i,
                         out_valid, in_ready, out_cout, out_sum, expv[32], expv[31:0]); end
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        tests++; if ({in_ready, out_valid, busy} !== 3'b100) begin fails++;
            $display("FAIL %s_handoff got rdy/vld/busy=%b want 100", name, {in_ready, out_valid, busy}); end
    endtask

    task automatic test_directed();
        do_op(32'h000000FF, 32'h00000001, 1'b0, 0, "carry_byte");
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 0, "ripple_all");
        do_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 10, "stall10");
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++)
            do_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)), "rand");
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp_q[$];
        int vcyc[$];
        exp_q.push_back({1'b0, 32'd1} + {1'b0, 32'd2});
        exp_q.push_back({1'b0, 32'h80000000} + {1'b0, 32'h80000000});
        @(negedge clk);
        in_valid = 1; in_a = 32'd1; in_b = 32'd2; in_cin = 0; out_ready = 1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) begin in_a = 32'h80000000; in_b = 32'h80000000; end
            if (c == 7) in_valid = 0;
            if (out_valid === 1'b1) begin
                vcyc.push_back(c);
                tests++;
                if (exp_q.size() == 0 || {out_cout, out_sum} !== exp_q[0]) begin fails++;
                    $display("FAIL b2b_result cycle %0d got %b/%h", c, out_cout, out_sum); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (c == 6) begin
                tests++; if (in_ready !== 1'b1) begin fails++;
                    $display("FAIL b2b_rearm got in_ready=%b want 1", in_ready); end
            end
        end
        out_ready = 0;
        tests++;
        if (vcyc.size() != 2 || vcyc[0] != 5 || vcyc[1] != 11) begin fails++;
            $display("FAIL b2b_timing got %0d results, first at %0d want 2 at 5 and 11", vcyc.size(),
                     (vcyc.size() > 0) ? vcyc[0] : -1); end
    endtask

    task automatic test_reset_midrun();
        int seen;
        @(negedge clk);
        in_valid = 1; in_a = 32'hDEADBEEF; in_b = 32'h01234567; in_cin = 1; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        tests++;
        if ({in_ready, out_valid, busy} !== 3'b100 || {out_sum, out_cout} !== 33'd0 ||
            {adder_a, adder_b, adder_cin} !== 17'd0) begin fails++;
            $display("FAIL midrun_reset got rdy/vld/busy=%b sum=%h aa=%h", {in_ready, out_valid, busy},
                     out_sum, adder_a); end
        seen = 0;
        repeat (8) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
        out_ready = 0;
        tests++; if (seen != 0) begin fails++;
            $display("FAIL midrun_no_valid got %0d valid cycles want 0", seen); end
        do_op(32'd5, 32'd7, 1'b0, 0, "after_reset");
    endtask

    task automatic op_n1(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [8:0] expv;
        int cyc;
        expv = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        @(negedge clk);
        in_valid1 = 1; in_a1 = a; in_b1 = b; in_cin1 = cin;
        @(negedge clk);
        in_valid1 = 0; in_a1 = 8'($urandom);
        tests++; if ({adder_a1, adder_b1, adder_cin1} !== {a, b, cin}) begin fails++;
            $display("FAIL n1_adder got %h %h %b want %h %h %b", adder_a1, adder_b1, adder_cin1, a, b, cin); end
        cyc = 1;
        while (out_valid1 !== 1'b1 && cyc <= 10) begin @(negedge clk); cyc++; end
        tests++; if (cyc !== 2 || {out_cout1, out_sum1} !== expv) begin fails++;
            $display("FAIL n1_result got %b/%h at %0d want %b/%h at 2", out_cout1, out_sum1, cyc,
                     expv[8], expv[7:0]); end
        out_ready1 = 1;
        @(negedge clk);
        out_ready1 = 0;
    endtask

    task automatic test_single_chunk();
        op_n1(8'hF0, 8'h20, 1'b1);
        for (int n = 0; n < 5; n++) op_n1(8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        test_single_chunk();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
